// File: rtl/ram_access_arbiter.sv
// ----------------------------------------------------------------------------
// ram_access_arbiter
//
// Shares a single-port SPI-slave RAM between two requesters. Each accepted
// 8-bit-address transaction becomes two 10-bit command beats on the RAM port.
// The top two bits of a beat select its meaning:
//    00 write-addr, 01 write-data, 10 read-addr, 11 read-data
// Reads then wait for ram_tx_valid, or give up after TIMEOUT cycles and
// return an error. Arbitration is round-robin. Only one transaction is in
// flight at a time.
//
// Ports
//    clk, rst_n                  clock (rising edge), async active-low reset
//    reqN_valid/ready            request handshake (ready is combinational)
//    reqN_we/addr/wdata          request payload (wdata ignored on reads)
//    rspN_valid/rdata/err        one-cycle completion pulse with read data
//                                and timeout flag
//    ram_din, ram_rx_valid       command beat towards the RAM
//    ram_dout, ram_tx_valid      read data returned by the RAM
// ----------------------------------------------------------------------------
module ram_access_arbiter #(
   parameter int TIMEOUT = 16,
   parameter int TO_W    = 5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req0_valid,
   output logic       req0_ready,
   input  logic       req0_we,
   input  logic [7:0] req0_addr,
   input  logic [7:0] req0_wdata,
   output logic       rsp0_valid,
   output logic [7:0] rsp0_rdata,
   output logic       rsp0_err,
   input  logic       req1_valid,
   output logic       req1_ready,
   input  logic       req1_we,
   input  logic [7:0] req1_addr,
   input  logic [7:0] req1_wdata,
   output logic       rsp1_valid,
   output logic [7:0] rsp1_rdata,
   output logic       rsp1_err,
   output logic [9:0] ram_din,
   output logic       ram_rx_valid,
   input  logic [7:0] ram_dout,
   input  logic       ram_tx_valid
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_DATA,
      S_WAIT_RD,
      S_RESP
   } state_e;

   localparam logic [1:0]      CMD_WR_ADDR = 2'b00;
   localparam logic [1:0]      CMD_WR_DATA = 2'b01;
   localparam logic [1:0]      CMD_RD_ADDR = 2'b10;
   localparam logic [1:0]      CMD_RD_DATA = 2'b11;
   localparam logic [TO_W-1:0] TO_LAST     = TO_W'(TIMEOUT - 1);

   state_e            state_q, state_d;
   logic              we_q, we_d;
   logic [7:0]        addr_q, addr_d;
   logic [7:0]        wdata_q, wdata_d;
   logic              port_q, port_d;
   logic              last_grant_q, last_grant_d;
   logic [TO_W-1:0]   cnt_q, cnt_d;
   logic [9:0]        ram_din_q, ram_din_d;
   logic              ram_rx_valid_q, ram_rx_valid_d;
   logic              rsp0_valid_q, rsp0_valid_d;
   logic [7:0]        rsp0_rdata_q, rsp0_rdata_d;
   logic              rsp0_err_q, rsp0_err_d;
   logic              rsp1_valid_q, rsp1_valid_d;
   logic [7:0]        rsp1_rdata_q, rsp1_rdata_d;
   logic              rsp1_err_q, rsp1_err_d;

   // Arbitration and payload selection
   logic              grant_ok;
   logic              grant_port;
   logic              sel_we;
   logic [7:0]        sel_addr;
   logic [7:0]        sel_wdata;

   // Completion produced this cycle, routed to the latched port below
   logic              rsp_fire;
   logic [7:0]        rsp_data;
   logic              rsp_err_bit;

   always_comb begin
      grant_ok   = 1'b0;
      grant_port = 1'b0;
      if (req0_valid && req1_valid) begin
         // Under contention the port that did not win last time goes next.
         grant_ok   = 1'b1;
         grant_port = ~last_grant_q;
      end else if (req0_valid) begin
         grant_ok   = 1'b1;
         grant_port = 1'b0;
      end else if (req1_valid) begin
         grant_ok   = 1'b1;
         grant_port = 1'b1;
      end
      sel_we    = grant_port ? req1_we    : req0_we;
      sel_addr  = grant_port ? req1_addr  : req0_addr;
      sel_wdata = grant_port ? req1_wdata : req0_wdata;
   end

   // Ready is qualified with rst_n so nothing is accepted while reset is held.
   assign req0_ready = rst_n && (state_q == S_IDLE) && grant_ok && !grant_port;
   assign req1_ready = rst_n && (state_q == S_IDLE) && grant_ok &&  grant_port;

   always_comb begin
      // NOTE: every signal written here gets a default first; a branch that
      // forgets an assignment then holds the default instead of a latch.
      state_d        = state_q;
      we_d           = we_q;
      addr_d         = addr_q;
      wdata_d        = wdata_q;
      port_d         = port_q;
      last_grant_d   = last_grant_q;
      cnt_d          = cnt_q;
      ram_din_d      = '0;
      ram_rx_valid_d = 1'b0;
      rsp_fire       = 1'b0;
      rsp_data       = '0;
      rsp_err_bit    = 1'b0;

      // Outputs are registered, so each state computes the beat that the
      // NEXT state presents on the RAM port.
      case (state_q)
         S_IDLE: begin
            if (grant_ok) begin
               we_d           = sel_we;
               addr_d         = sel_addr;
               wdata_d        = sel_wdata;
               port_d         = grant_port;
               last_grant_d   = grant_port;
               ram_rx_valid_d = 1'b1;
               ram_din_d      = {sel_we ? CMD_WR_ADDR : CMD_RD_ADDR, sel_addr};
               state_d        = S_ADDR;
            end
         end
         S_ADDR: begin
            ram_rx_valid_d = 1'b1;
            ram_din_d      = {we_q ? CMD_WR_DATA : CMD_RD_DATA,
                              we_q ? wdata_q : 8'h00};
            state_d        = S_DATA;
         end
         S_DATA: begin
            if (we_q) begin
               rsp_fire = 1'b1;
               state_d  = S_RESP;
            end else begin
               cnt_d   = '0;
               state_d = S_WAIT_RD;
            end
         end
         S_WAIT_RD: begin
            // Returned data wins over a timeout expiring in the same cycle.
            if (ram_tx_valid) begin
               rsp_fire = 1'b1;
               rsp_data = ram_dout;
               state_d  = S_RESP;
            end else if (cnt_q == TO_LAST) begin
               rsp_fire    = 1'b1;
               rsp_err_bit = 1'b1;
               state_d     = S_RESP;
            end else begin
               cnt_d = cnt_q + TO_W'(1);
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      rsp0_valid_d = rsp_fire && !port_q;
      rsp0_rdata_d = (rsp_fire && !port_q) ? rsp_data : 8'h00;
      rsp0_err_d   = rsp_fire && !port_q && rsp_err_bit;
      rsp1_valid_d = rsp_fire &&  port_q;
      rsp1_rdata_d = (rsp_fire &&  port_q) ? rsp_data : 8'h00;
      rsp1_err_d   = rsp_fire &&  port_q && rsp_err_bit;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         we_q           <= 1'b0;
         addr_q         <= '0;
         wdata_q        <= '0;
         port_q         <= 1'b0;
         last_grant_q   <= 1'b1;     // port 0 wins the first contention
         cnt_q          <= '0;
         ram_din_q      <= '0;
         ram_rx_valid_q <= 1'b0;
         rsp0_valid_q   <= 1'b0;
         rsp0_rdata_q   <= '0;
         rsp0_err_q     <= 1'b0;
         rsp1_valid_q   <= 1'b0;
         rsp1_rdata_q   <= '0;
         rsp1_err_q     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make every flop sample the values
         // from before this edge, independent of statement order.
         state_q        <= state_d;
         we_q           <= we_d;
         addr_q         <= addr_d;
         wdata_q        <= wdata_d;
         port_q         <= port_d;
         last_grant_q   <= last_grant_d;
         cnt_q          <= cnt_d;
         ram_din_q      <= ram_din_d;
         ram_rx_valid_q <= ram_rx_valid_d;
         rsp0_valid_q   <= rsp0_valid_d;
         rsp0_rdata_q   <= rsp0_rdata_d;
         rsp0_err_q     <= rsp0_err_d;
         rsp1_valid_q   <= rsp1_valid_d;
         rsp1_rdata_q   <= rsp1_rdata_d;
         rsp1_err_q     <= rsp1_err_d;
      end
   end

   assign ram_din      = ram_din_q;
   assign ram_rx_valid = ram_rx_valid_q;
   assign rsp0_valid   = rsp0_valid_q;
   assign rsp0_rdata   = rsp0_rdata_q;
   assign rsp0_err     = rsp0_err_q;
   assign rsp1_valid   = rsp1_valid_q;
   assign rsp1_rdata   = rsp1_rdata_q;
   assign rsp1_err     = rsp1_err_q;

endmodule

// File: doc/ram_access_arbiter.md
Name: ram_access_arbiter

Overview:
- Shares the single-port SPI-slave RAM between two requesters (port 0: SPI command path, port 1: on-chip host/DMA).
- Converts each 8-bit-address read/write transaction into the RAM's two-beat 10-bit command protocol: din[9:8] = 00 write-addr, 01 write-data, 10 read-addr, 11 read-data.
- Round-robin arbitration, one transaction in flight, read-return timeout.

Parameters:
- TIMEOUT, 16, max cycles spent in WAIT_RD for ram_tx_valid before an error response.
- TO_W, 5, timeout counter width; must satisfy 2**TO_W > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- reqN_valid  in  1  request present (N = 0,1)
- reqN_ready  out  1  request accepted this cycle (combinational)
- reqN_we  in  1  1 = write, 0 = read
- reqN_addr  in  8  RAM address
- reqN_wdata  in  8  write data (ignored on reads)
- rspN_valid  out  1  one-cycle completion pulse
- rspN_rdata  out  8  read data, valid with rspN_valid (0 for writes)
- rspN_err  out  1  read timed out, valid with rspN_valid
- ram_din  out  10  command word to RAM
- ram_rx_valid  out  1  command word valid
- ram_dout  in  8  RAM read data
- ram_tx_valid  in  1  RAM read data valid

Behaviour:
- Reset (async, rst_n=0): state=IDLE; ram_din=0, ram_rx_valid=0, rspN_valid=0, rspN_rdata=0, rspN_err=0, timeout counter=0, last_grant=1 (port 0 wins first contention). Reset mid-transaction aborts it: no response, no further RAM beats.
- All outputs registered except reqN_ready.
- IDLE:
  - Grant rule: if both valid, grant the port != last_grant; if one valid, grant it.
  - reqN_ready=1 only for the granted port, only in IDLE.
  - On handshake: latch we/addr/wdata and the grant index, update last_grant, go to ADDR.
  - ready is 0 in all other states.
- ADDR (1 cycle): ram_rx_valid=1, ram_din={we?2'b00:2'b10, addr}. Go to DATA.
- DATA (1 cycle): ram_rx_valid=1, ram_din={we?2'b01:2'b11, we?wdata:8'h00}.
  - Write: go to RESP.
  - Read: clear counter, go to WAIT_RD.
- WAIT_RD: ram_rx_valid=0, ram_din=0.
  - ram_tx_valid=1: capture ram_dout, err=0, go to RESP.
  - Otherwise counter++; when counter reaches TIMEOUT-1 with no tx_valid: rdata=0, err=1, go to RESP.
  - tx_valid takes precedence over timeout in the same cycle.
- RESP (1 cycle): rspN_valid=1 for the latched port only, with rdata/err. Other port's rsp outputs stay 0. Go to IDLE.
- Latency from handshake cycle (cycle 0):
  - ADDR beat cycle 1, DATA beat cycle 2.
  - Write rsp cycle 3.
  - Read rsp at cycle 4+k, where k = cycles from entering WAIT_RD to tx_valid (k=0 if tx_valid is present on the first WAIT_RD cycle).
  - Minimum back-to-back issue: one transaction per 4 cycles (writes).
- Boundaries:
  - ram_tx_valid outside WAIT_RD is ignored.
  - Requests arriving during a transaction wait; valid must be held by the requester until ready.
  - Addresses 0x00 and 0xFF pass unchanged.
  - ram_rx_valid is never asserted outside ADDR/DATA.

Test Plan:
- Reset: hold rst_n=0 with req0_valid=1 -> all outputs 0 and no ready; first negedge after release -> req0 granted.
- Write: req0 we=1 addr=0x3C wdata=0xA5 -> ram_din 0x03C then 0x1A5 with rx_valid on consecutive cycles; rsp0_valid pulse at cycle 3 with err=0.
- Read: req1 we=0 addr=0x3C; RAM model returns tx_valid with dout=0xA5 one cycle after DATA -> ram_din 0x23C, 0x300; rsp1_rdata=0xA5, err=0, rsp0_valid stays 0.
- Contention: both valid continuously for 6 transactions -> grants alternate 0,1,0,1,0,1; no RAM beat overlap.
- Timeout: read with RAM model never asserting tx_valid -> rsp_valid exactly 16 cycles after entering WAIT_RD, err=1, rdata=0; a late tx_valid is ignored.
- Reset mid-read: rst_n=0 during WAIT_RD -> no rsp pulse; next request is served normally, with port 0 favoured first.
